// File: rtl/alu_pkg.sv
// Shared op-code and state definitions for the sequential ALU and the CPU decoder.
package alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADC   = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SBC   = 5'd3;
    localparam logic [4:0] OP_OR    = 5'd4;
    localparam logic [4:0] OP_AND   = 5'd5;
    localparam logic [4:0] OP_NOT   = 5'd6;
    localparam logic [4:0] OP_XOR   = 5'd7;
    localparam logic [4:0] OP_CMP   = 5'd8;
    localparam logic [4:0] OP_PASS  = 5'd9;
    localparam logic [4:0] OP_SHL   = 5'd12;
    localparam logic [4:0] OP_SHR   = 5'd13;
    localparam logic [4:0] OP_MUL16 = 5'd16;
    localparam logic [4:0] OP_MULLO = 5'd17;
    localparam logic [4:0] OP_MULHI = 5'd18;
    localparam logic [4:0] OP_DIVU  = 5'd20;
    localparam logic [4:0] OP_REMU  = 5'd21;
    localparam logic [4:0] OP_DIVS  = 5'd22;
    localparam logic [4:0] OP_REMS  = 5'd23;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

    function automatic logic is_mul_op(logic [4:0] op);
        return (op == OP_MUL16) || (op == OP_MULLO) || (op == OP_MULHI);
    endfunction

    // Ops 20..23 share the prefix 3'b101.
    function automatic logic is_div_op(logic [4:0] op);
        return op[4:2] == 3'b101;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-read stage and the sequential ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [7:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] c;
    logic             carry_out;
    logic             is_zero;
    logic             is_negative;
    logic             div_zero;

    modport master (
        output start, op, a, b, carry_in,
        input  ready, valid, c, carry_out, is_zero, is_negative, div_zero
    );

    modport slave (
        input  start, op, a, b, carry_in,
        output ready, valid, c, carry_out, is_zero, is_negative, div_zero
    );
endinterface

// File: rtl/alu_divider.sv
// Iterative restoring divider: WIDTH DIV iterations on magnitudes, then one FIX cycle
// applying the signs. quotient/remainder/div_zero are meaningful while done is high.
module alu_divider import alu_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             div_zero
);
    localparam int unsigned    LastIter = WIDTH - 1;
    localparam logic [SHW:0]   CntLast  = LastIter[SHW:0];
    localparam logic [SHW:0]   CntStep  = {{SHW{1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] r_q, r_d;     // partial remainder, always < divisor (or 0 divisor)
    logic [WIDTH-1:0] d_q, d_d;
    logic             negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;

    logic [WIDTH:0]   shifted, rem_sub;
    logic             sa, sb, unused_sub;

    assign shifted    = {r_q, q_q[WIDTH-1]};
    assign rem_sub    = shifted - {1'b0, d_q};
    assign unused_sub = rem_sub[WIDTH];
    assign sa         = signed_op & a[WIDTH-1];
    assign sb         = signed_op & b[WIDTH-1];

    // Next state: load magnitudes, one restoring step per DIV cycle, FIX returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        if (load) begin
            q_d     = sa ? -a : a;
            d_d     = sb ? -b : b;
            r_d     = '0;
            negq_d  = sa ^ sb;
            negr_d  = sa;
            dz_d    = (b == '0);
            cnt_d   = '0;
            state_d = DIV;
        end else begin
            case (state_q)
                DIV: begin
                    if (shifted >= {1'b0, d_q}) begin
                        r_d = rem_sub[WIDTH-1:0];
                        q_d = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_d = shifted[WIDTH-1:0];
                        q_d = {q_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CntStep;
                    if (cnt_q == CntLast) state_d = FIX;
                end
                FIX:     state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Divider state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
        end
    end

    // Sign fix-up. Zero divisor yields an all-ones quotient and remainder == dividend;
    // MIN / -1 falls out naturally as quotient MIN, remainder 0.
    always_comb begin
        quotient  = dz_q ? '1 : (negq_q ? -q_q : q_q);
        remainder = negr_q ? -r_q : r_q;
        done      = (state_q == FIX);
        div_zero  = dz_q;
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: registered single-cycle ops, shift-add multiplier, and the divider
// sub-module, behind a start/ready/valid handshake.
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int               HALF     = WIDTH / 2;
    localparam int unsigned      LastIter = WIDTH - 1;
    localparam logic [SHW:0]     CntLast  = LastIter[SHW:0];
    localparam logic [SHW:0]     CntStep  = {{SHW{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] WidthVec = WIDTH'(WIDTH);

    state_e           state_q, state_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] ma_q, ma_d, mhi_q, mhi_d, mlo_q, mlo_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             carry_q, carry_d, valid_q, valid_d, dz_q, dz_d;

    logic [4:0]       op5;
    logic             unused_op, accept, div_load, div_done, div_dz;
    logic [WIDTH:0]   ax, bx, cx, diff, alu_res, msum;
    logic [WIDTH-1:0] shl_res, shr_res, mhi_n, mlo_n, div_quo, div_rem;

    assign op5       = bus.op[4:0];
    assign unused_op = ^bus.op[7:5];
    assign accept    = bus.start && (state_q == IDLE);
    assign div_load  = accept && is_div_op(op5);
    assign ax        = {1'b0, bus.a};
    assign bx        = {1'b0, bus.b};
    assign cx        = {{WIDTH{1'b0}}, bus.carry_in};
    assign diff      = ax - bx;

    // One shift-add step: add multiplicand when the multiplier LSB is set, shift right.
    assign msum  = {1'b0, mhi_q} + (mlo_q[0] ? {1'b0, ma_q} : '0);
    assign mhi_n = msum[WIDTH:1];
    assign mlo_n = {msum[0], mlo_q[WIDTH-1:1]};

    alu_divider #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .signed_op (bus.op[1]),
        .a         (bus.a),
        .b         (bus.b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done),
        .div_zero  (div_dz)
    );

    // Barrel shifts; amounts of WIDTH or more give zero.
    always_comb begin
        shl_res = (bus.b >= WidthVec) ? '0 : bus.a << bus.b[SHW-1:0];
        shr_res = (bus.b >= WidthVec) ? '0 : bus.a >> bus.b[SHW-1:0];
    end

    // Single-cycle results at WIDTH+1 bits; bit WIDTH becomes carry_out.
    always_comb begin
        alu_res = '0;
        case (op5)
            OP_ADD:  alu_res = ax + bx;
            OP_ADC:  alu_res = ax + bx + cx;
            OP_SUB:  alu_res = diff;
            OP_SBC:  alu_res = ax - bx - cx;
            OP_OR:   alu_res = {1'b0, bus.a | bus.b};
            OP_AND:  alu_res = {1'b0, bus.a & bus.b};
            OP_NOT:  alu_res = {1'b0, ~bus.a};
            OP_XOR:  alu_res = {1'b0, bus.a ^ bus.b};
            OP_CMP: begin
                if (diff[WIDTH-1])      alu_res = '1;
                else if (bus.a == bus.b) alu_res = '0;
                else                    alu_res = {{WIDTH{1'b0}}, 1'b1};
            end
            OP_PASS: alu_res = ax;
            OP_SHL:  alu_res = {1'b0, shl_res};
            OP_SHR:  alu_res = {1'b0, shr_res};
            default: alu_res = '0;
        endcase
    end

    // Handshake FSM and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        ma_d    = ma_q;
        mhi_d   = mhi_q;
        mlo_d   = mlo_q;
        c_d     = c_q;
        carry_d = carry_q;
        valid_d = 1'b0;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d = op5;
                    if (is_mul_op(op5)) begin
                        dz_d    = 1'b0;
                        ma_d    = (op5 == OP_MUL16) ? {{HALF{1'b0}}, bus.a[HALF-1:0]} : bus.a;
                        mlo_d   = (op5 == OP_MUL16) ? {{HALF{1'b0}}, bus.b[HALF-1:0]} : bus.b;
                        mhi_d   = '0;
                        cnt_d   = '0;
                        state_d = MUL;
                    end else if (is_div_op(op5)) begin
                        state_d = DIV;
                    end else begin
                        dz_d    = 1'b0;
                        c_d     = alu_res[WIDTH-1:0];
                        carry_d = alu_res[WIDTH];
                        valid_d = 1'b1;
                    end
                end
            end
            MUL: begin
                mhi_d = mhi_n;
                mlo_d = mlo_n;
                cnt_d = cnt_q + CntStep;
                if (cnt_q == CntLast) begin
                    c_d     = (op_q == OP_MULHI) ? mhi_n : mlo_n;
                    carry_d = 1'b0;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            DIV: begin
                if (div_done) begin
                    // Odd codes (remu/rems) select the remainder.
                    c_d     = op_q[0] ? div_rem : div_quo;
                    carry_d = 1'b0;
                    dz_d    = div_dz;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            ma_q    <= '0;
            mhi_q   <= '0;
            mlo_q   <= '0;
            c_q     <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            ma_q    <= ma_d;
            mhi_q   <= mhi_d;
            mlo_q   <= mlo_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.ready       = (state_q == IDLE);
    assign bus.valid       = valid_q;
    assign bus.c           = c_q;
    assign bus.carry_out   = carry_q;
    assign bus.is_zero     = (c_q == '0);
    assign bus.is_negative = c_q[WIDTH-1];
    assign bus.div_zero    = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32 and WIDTH=16 against an arithmetic model.
module tb_alu_seq;

    typedef struct {
        logic [63:0] c;
        bit          carry;
        bit          dz;
        int          lat;
        int          due;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst32, rst16;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) bus32();
    alu_seq_if #(.WIDTH(16)) bus16();

    alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(rst32), .bus(bus32));
    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .reset(rst16), .bus(bus16));

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb32[$];
    exp_t sb16[$];
    exp_t m32, m16;

    logic [4:0] op_tab [22] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                5'd12, 5'd13, 5'd16, 5'd17, 5'd18, 5'd20, 5'd21, 5'd22,
                                5'd23, 5'd10, 5'd19, 5'd27};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // Reference results from plain integer arithmetic on w-bit values.
    function automatic exp_t model(int w, logic [7:0] op8, logic [63:0] a_in, logic [63:0] b_in,
                                   bit cin);
        exp_t        e;
        logic [63:0] mask  = (64'd1 << w) - 1;
        logic [63:0] hmask = (64'd1 << (w / 2)) - 1;
        logic [63:0] a     = a_in & mask;
        logic [63:0] b     = b_in & mask;
        logic [63:0] r     = 64'd0;
        longint      sa, sb, minv;
        int          op    = int'(op8[4:0]);
        bit          addc  = 1'b0;
        e.lat = 1;
        minv  = -(longint'(1) << (w - 1));
        sa    = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb    = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        case (op)
            0:  begin r = a + b;        addc = 1'b1; end
            1:  begin r = a + b + 64'(cin); addc = 1'b1; end
            2:  begin r = a - b;        addc = 1'b1; end
            3:  begin r = a - b - 64'(cin); addc = 1'b1; end
            4:  r = a | b;
            5:  r = a & b;
            6:  r = ~a & mask;
            7:  r = a ^ b;
            8:  begin
                addc = 1'b1;
                if (sa - sb < 0 && ((a - b) & mask) >> (w - 1) != 0) r = (mask << 1) | 64'd1;
                else if (((a - b) & mask) >> (w - 1) != 0)             r = (mask << 1) | 64'd1;
                else if (a == b)                                       r = 64'd0;
                else                                                   r = 64'd1;
            end
            9:  r = a;
            12: r = (b >= 64'(w)) ? 64'd0 : (a << b);
            13: r = (b >= 64'(w)) ? 64'd0 : (a >> b);
            16: begin r = (a & hmask) * (b & hmask); e.lat = w + 1; end
            17: begin r = a * b;                     e.lat = w + 1; end
            18: begin r = (a * b) >> w;              e.lat = w + 1; end
            20: begin r = (b == 0) ? mask : a / b;   e.lat = w + 2; end
            21: begin r = (b == 0) ? a : a % b;      e.lat = w + 2; end
            22: begin
                e.lat = w + 2;
                if (b == 0)                      r = mask;
                else if (sa == minv && sb == -1) r = 64'(minv);
                else                             r = 64'(sa / sb);
            end
            23: begin
                e.lat = w + 2;
                if (b == 0)                      r = a;
                else if (sa == minv && sb == -1) r = 64'd0;
                else                             r = 64'(sa % sb);
            end
            default: r = 64'd0;
        endcase
        e.c     = r & mask;
        e.carry = addc ? r[w] : 1'b0;
        e.dz    = (op >= 20 && op <= 23) && (b == 0);
        e.due   = 0;
        e.name  = "";
        return e;
    endfunction

    function automatic logic [63:0] rand_val(int w);
        logic [63:0] m = (64'd1 << w) - 1;
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return m;
            2:       return 64'd1 << (w - 1);
            3:       return 64'($urandom_range(0, 40));
            default: return {32'($urandom), 32'($urandom)} & m;
        endcase
    endfunction

    // Wait for ready, present one request, record its expected response.
    task automatic issue(input bit sel, input logic [7:0] op, input logic [63:0] a,
                         input logic [63:0] b, input bit cin, input string name);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!(sel ? bus16.ready : bus32.ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(sel ? bus16.ready : bus32.ready)) begin
            checks++;
            failures++;
            $display("FAIL %s: ready stayed 0 for %0d cycles, expected 1", name, n);
            return;
        end
        e      = model(sel ? 16 : 32, op, a, b, cin);
        e.due  = cyc + e.lat;
        e.name = name;
        if (sel) begin
            bus16.start = 1'b1; bus16.op = op; bus16.a = a[15:0]; bus16.b = b[15:0];
            bus16.carry_in = cin;
            sb16.push_back(e);
        end else begin
            bus32.start = 1'b1; bus32.op = op; bus32.a = a[31:0]; bus32.b = b[31:0];
            bus32.carry_in = cin;
            sb32.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sel) begin
            bus16.start = 1'b0; bus16.a = 16'($urandom); bus16.b = 16'($urandom);
            bus16.op = 8'($urandom);
        end else begin
            bus32.start = 1'b0; bus32.a = $urandom; bus32.b = $urandom;
            bus32.op = 8'($urandom);
        end
    endtask

    // Assert start for one cycle while the 32-bit unit is busy; it must be dropped.
    task automatic poke32();
        @(negedge clk);
        if (!bus32.ready) begin
            bus32.start = 1'b1; bus32.op = 8'd0; bus32.a = $urandom; bus32.b = $urandom;
            @(posedge clk);
            #1 bus32.start = 1'b0;
        end
    endtask

    task automatic check_reset(input bit sel, input string tag);
        if (sel) begin
            check({tag, " ready"}, 64'(bus16.ready), 64'd1);
            check({tag, " valid"}, 64'(bus16.valid), 64'd0);
            check({tag, " c"}, 64'(bus16.c), 64'd0);
            check({tag, " flags"}, {60'd0, bus16.carry_out, bus16.is_zero, bus16.is_negative,
                  bus16.div_zero}, 64'b0100);
        end else begin
            check({tag, " ready"}, 64'(bus32.ready), 64'd1);
            check({tag, " valid"}, 64'(bus32.valid), 64'd0);
            check({tag, " c"}, 64'(bus32.c), 64'd0);
            check({tag, " flags"}, {60'd0, bus32.carry_out, bus32.is_zero, bus32.is_negative,
                  bus32.div_zero}, 64'b0100);
        end
    endtask

    // Monitor for the 32-bit unit: every valid must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst32 && bus32.valid) begin
            if (sb32.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w32 spurious valid: got c=0x%0h, expected no valid", bus32.c);
            end else begin
                m32 = sb32.pop_front();
                check({m32.name, " c"}, 64'(bus32.c), m32.c);
                check({m32.name, " flags"}, {60'd0, bus32.carry_out, bus32.is_zero,
                      bus32.is_negative, bus32.div_zero},
                      {60'd0, m32.carry, m32.c == 64'd0, m32.c[31], m32.dz});
                check({m32.name, " cycle"}, 64'(cyc), 64'(m32.due));
            end
        end
    end

    // Monitor for the 16-bit unit.
    always @(negedge clk) begin
        if (!rst16 && bus16.valid) begin
            if (sb16.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w16 spurious valid: got c=0x%0h, expected no valid", bus16.c);
            end else begin
                m16 = sb16.pop_front();
                check({m16.name, " c"}, 64'(bus16.c), m16.c);
                check({m16.name, " flags"}, {60'd0, bus16.carry_out, bus16.is_zero,
                      bus16.is_negative, bus16.div_zero},
                      {60'd0, m16.carry, m16.c == 64'd0, m16.c[15], m16.dz});
                check({m16.name, " cycle"}, 64'(cyc), 64'(m16.due));
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((sb32.size() != 0 || sb16.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb32.size() != 0 || sb16.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d/%0d responses outstanding, expected 0",
                     sb32.size(), sb16.size());
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst32 = 1'b1; rst16 = 1'b1;
        bus32.start = 1'b0; bus32.op = '0; bus32.a = '0; bus32.b = '0; bus32.carry_in = 1'b0;
        bus16.start = 1'b0; bus16.op = '0; bus16.a = '0; bus16.b = '0; bus16.carry_in = 1'b0;
        repeat (3) @(negedge clk);
        check_reset(1'b0, "w32 reset");
        check_reset(1'b1, "w16 reset");
        rst32 = 1'b0; rst16 = 1'b0;

        // Directed 32-bit cases.
        issue(0, 8'd0,  64'hFFFF_FFFF, 64'd1, 1'b0, "add wrap");
        issue(0, 8'd3,  64'd0, 64'd0, 1'b1, "sbc borrow");
        issue(0, 8'd1,  64'h7FFF_FFFF, 64'd0, 1'b1, "adc cin");
        issue(0, 8'd12, 64'd1, 64'd31, 1'b0, "shl 31");
        issue(0, 8'd12, 64'd1, 64'd32, 1'b0, "shl 32");
        issue(0, 8'd13, 64'h8000_0000, 64'd4, 1'b0, "shr 4");
        issue(0, 8'd13, 64'hFFFF_FFFF, 64'h1_0000, 1'b0, "shr big");
        issue(0, 8'd8,  64'd3, 64'd5, 1'b0, "cmp lt");
        issue(0, 8'd8,  64'd5, 64'd5, 1'b0, "cmp eq");
        issue(0, 8'd8,  64'd9, 64'd5, 1'b0, "cmp gt");
        issue(0, 8'd18, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, "mulhi max");
        poke32();
        poke32();
        issue(0, 8'd17, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, "mullo max");
        issue(0, 8'd16, 64'hABCD_FFFF, 64'h1234_FFFF, 1'b0, "mul16");
        issue(0, 8'd22, 64'hFFFF_FFF9, 64'd2, 1'b0, "divs -7/2");
        issue(0, 8'd23, 64'hFFFF_FFF9, 64'd2, 1'b0, "rems -7/2");
        issue(0, 8'd22, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, "divs ovf");
        issue(0, 8'd23, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, "rems ovf");
        issue(0, 8'd20, 64'h1234_5678, 64'd0, 1'b0, "divu by0");
        issue(0, 8'd22, 64'hFFFF_FF00, 64'd0, 1'b0, "divs by0");
        issue(0, 8'd10, 64'h1234_5678, 64'd1, 1'b0, "undef 10");
        issue(0, 8'hE0, 64'd7, 64'd8, 1'b0, "add hi op bits");
        issue(0, 8'd21, 64'h1234_5678, 64'd0, 1'b0, "remu by0");

        // Reset in the 10th cycle of a divide: response discarded, outputs cleared at once.
        issue(0, 8'd20, 64'd100, 64'd7, 1'b0, "divu aborted");
        repeat (9) @(posedge clk);
        #2 rst32 = 1'b1;
        #1 check_reset(1'b0, "w32 mid-div reset");
        sb32.delete();
        repeat (2) @(negedge clk);
        rst32 = 1'b0;
        issue(0, 8'd0, 64'd40, 64'd2, 1'b0, "add after reset");

        // Randomized 32-bit traffic.
        for (int i = 0; i < 60; i++) begin
            issue(0, {3'($urandom_range(0, 7)), op_tab[$urandom_range(0, 21)]},
                  rand_val(32), rand_val(32), 1'($urandom), "w32 rand");
        end
        drain();

        // 16-bit build.
        issue(1, 8'd17, 64'h00FF, 64'h0101, 1'b0, "w16 mullo");
        issue(1, 8'd0,  64'h0001, 64'h0002, 1'b0, "w16 b2b add0");
        issue(1, 8'd0,  64'hFFFF, 64'h0001, 1'b0, "w16 b2b add1");
        issue(1, 8'd2,  64'h0000, 64'h0001, 1'b0, "w16 b2b sub");
        issue(1, 8'd23, 64'h8000, 64'hFFFF, 1'b0, "w16 rems ovf");
        for (int i = 0; i < 40; i++) begin
            issue(1, {3'($urandom_range(0, 7)), op_tab[$urandom_range(0, 21)]},
                  rand_val(16), rand_val(16), 1'($urandom), "w16 rand");
        end
        drain();
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational 32-bit ALU. It keeps the same op set and encodings and adds a sequential datapath.
- Single-cycle ops are registered. Multiply uses an iterative shift-add unit. New signed and unsigned divide/remainder ops use an iterative restoring divider.
- Sits between the CPU register-file read stage and writeback. A start/valid handshake lets the CPU stall on multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width in bits; even, >= 8.
- SHW, $clog2(WIDTH), shift-amount field width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- op  in  8  operation code; only op[4:0] decoded.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- carry_in  in  1  carry/borrow for adc/sbc.
- ready  out  1  idle, can accept start.
- valid  out  1  one-cycle pulse: result outputs updated this cycle.
- c  out  WIDTH  result, held until next valid.
- carry_out  out  1  result bit WIDTH for add-class ops, else 0.
- is_zero  out  1  c == 0.
- is_negative  out  1  c[WIDTH-1].
- div_zero  out  1  last div/rem op had b == 0.

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, valid=0, c=0, carry_out=0, is_zero=1, is_negative=0, div_zero=0. Any in-flight op is discarded with no valid.
- Handshake:
  - start && ready latches op, a, b and carry_in. Inputs are don't-care afterwards.
  - start while ready=0 is ignored (no queueing).
  - valid is high for exactly 1 cycle per accepted start.
  - ready is 1 in the valid cycle, so back-to-back issue is allowed.
- Ops 0..9 (add, adc, sub, sbc, or, and, not, xor, cmp, pass a):
  - Latency 1: valid in the cycle after acceptance.
  - Results computed at WIDTH+1 bits; carry_out is bit WIDTH.
  - adc = a+b+carry_in; sbc = a-b-carry_in.
  - cmp = all-ones when (a-b)[WIDTH-1]=1, 0 when a==b, else 1. carry_out = cmp bit WIDTH, which is 1 only in the all-ones case.
- Op 12 shl, op 13 shr (logical):
  - Latency 1, using a barrel shifter rather than multiply.
  - Shift amount = b. If b >= WIDTH, the result is 0. This is defined behaviour, not undefined.
  - carry_out=0.
- Op 16 mul16: a[WIDTH/2-1:0]*b[WIDTH/2-1:0] unsigned, full WIDTH-bit product.
- Op 17 mullo, op 18 mulhi: unsigned 2*WIDTH product, low or high half.
- Multiply sequencing: state MUL runs WIDTH iterations of 1 bit each, so valid comes WIDTH+1 cycles after acceptance. carry_out=0.
- Op 20 divu, 21 remu, 22 divs, 23 rems:
  - States DIV (WIDTH iterations), then FIX (sign fix-up, 1 cycle). Valid comes WIDTH+2 cycles after acceptance for all four ops and all operand values.
  - Signed ops truncate toward zero; remainder takes the sign of the dividend.
  - Signed overflow (a = MIN, b = -1): quotient = MIN, remainder = 0, div_zero=0.
  - b == 0: quotient = all-ones, remainder = a, div_zero=1. Latency is unchanged.
  - carry_out=0.
- div_zero is updated only by div/rem ops. It clears on any other accepted op.
- Undefined op codes return c=0 and carry_out=0 with latency 1.
- FSM:
  - IDLE goes to MUL on a mul op, DIV on a div op; otherwise it stays in IDLE and registers the result.
  - MUL goes to IDLE when the iteration counter reaches WIDTH-1.
  - DIV goes to FIX at WIDTH-1; FIX goes to IDLE.
  - The iteration counter is SHW+1 bits and cleared on acceptance.

Decomposition:
- Shared package alu_pkg holds:
  - op-code localparams: OP_ADD=0 … OP_PASS=9, OP_SHL=12, OP_SHR=13, OP_MUL16=16, OP_MULLO=17, OP_MULHI=18, OP_DIVU=20, OP_REMU=21, OP_DIVS=22, OP_REMS=23;
  - state encoding: IDLE, MUL, DIV, FIX.
  The CPU decoder imports the same package.
- One sub-module, alu_divider:
  - iterative restoring divider with ports clk, reset, load, signed_op, a, b, quotient, remainder, done, div_zero;
  - owns the DIV/FIX sequencing, while alu_seq owns the handshake and result mux.

Test Plan:
- WIDTH=32: add a=0xFFFFFFFF b=1 -> valid 1 cycle later; c=0, carry_out=1, is_zero=1. Then sbc a=0 b=0 carry_in=1 -> c=0xFFFFFFFF, carry_out=1, is_negative=1.
- shl a=1 b=31 -> c=0x80000000. shl b=32 -> c=0. shr a=0x80000000 b=4 -> c=0x08000000. Each has valid at +1.
- mulhi a=0xFFFFFFFF b=0xFFFFFFFF -> c=0xFFFFFFFE at +33. mullo, same operands -> c=1. A start asserted mid-op is ignored and produces exactly one valid.
- divs a=-7 b=2 -> c=-3 at +34; rems, same operands -> c=-1. divs a=0x80000000 b=-1 -> c=0x80000000. divu b=0 -> c=0xFFFFFFFF, div_zero=1; remu b=0 -> c=a.
- Assert reset in the 10th cycle of a divu: all outputs return to reset values immediately and no valid appears. An add issued after reset is released completes normally.
- WIDTH=16 build: mullo 0x00FF*0x0101 -> c=0xFFFF at +17. Back-to-back: add issued in the valid cycle of the previous op is accepted with no bubble.
